// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered framebuffer controller.
package fb_pkg;

  localparam int unsigned ADDR_W_DEF  = 17;
  localparam int unsigned DEPTH_DEF   = 76800;
  localparam int unsigned PIXEL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_DRAW       = 2'd0,
    ST_WAIT_VSYNC = 2'd1,
    ST_CLEAR      = 2'd2
  } state_e;

  // Bank A is displayed out of reset, so the processor draws into bank B first.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic logic back_of(input logic front);
    return ~front;
  endfunction

endpackage

// File: rtl/fb_write_stage.sv
// Registered pixel write path with address range check and saturating drop counter.
// With FB_SWAP_CLEAR_EN a clear write port takes priority over processor writes.
module fb_write_stage
  import fb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef FB_SWAP_CLEAR_EN
  ,parameter int CLEAR_VAL = 0
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_en,
  input  logic               back_bank,
  input  logic               bb_we,
  input  logic [31:0]        din,
  input  logic [31:0]        waddr,
`ifdef FB_SWAP_CLEAR_EN
  input  logic               clr_we,
  input  logic [ADDR_W-1:0]  clr_addr,
`endif
  output logic               mem_we,
  output logic               mem_bank,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [PIXEL_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic               mem_we_q, mem_we_d;
  logic               mem_bank_q, mem_bank_d;
  logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
  logic [PIXEL_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               accept_s;
  logic               drop_s;
  logic               unused_din;

  assign unused_din = ^din[31:PIXEL_W];

  always_comb begin
    accept_s    = bb_we & draw_en & (waddr < DEPTH_W);
    drop_s      = bb_we & ~accept_s;
    mem_bank_d  = back_bank;
    mem_we_d    = accept_s;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef FB_SWAP_CLEAR_EN
    if (clr_we) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_addr;
      mem_wdata_d = PIXEL_W'(CLEAR_VAL);
    end else if (accept_s) begin
      mem_waddr_d = waddr[ADDR_W-1:0];
      mem_wdata_d = din[PIXEL_W-1:0];
    end else begin
      mem_waddr_d = mem_waddr_q;
    end
`else
    if (accept_s) begin
      mem_waddr_d = waddr[ADDR_W-1:0];
      mem_wdata_d = din[PIXEL_W-1:0];
    end else begin
      mem_waddr_d = mem_waddr_q;
    end
`endif
    if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_bank_q  <= BANK_B;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_bank_q  <= mem_bank_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_bank  = mem_bank_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Framebuffer swap controller: steers processor writes to the back bank and flips banks on vsync.
// Optional macro FB_SWAP_CLEAR_EN adds a CLEAR state that wipes the new back bank before drawing.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef FB_SWAP_CLEAR_EN
  ,parameter int CLEAR_VAL = 0
`endif
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               bb_we,
  input  logic [31:0]        din,
  input  logic [31:0]        waddr,
  input  logic               done,
  input  logic               vsync,
  output logic               swap,
  output logic               front_sel,
  output logic               mem_we,
  output logic               mem_bank,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [PIXEL_W-1:0] mem_wdata,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt
);

  state_e state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic   swap_q, swap_d;
  logic   busy_q, busy_d;
  logic   flip_s;

`ifdef FB_SWAP_CLEAR_EN
  // One extra count past the last address lets the final clear write land before swap.
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              clr_last_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  assign clr_last_s = (clr_cnt_q == (ADDR_W+1)'(DEPTH));
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_DRAW;
      front_sel_q <= BANK_A;
      swap_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FB_SWAP_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_q      <= swap_d;
      busy_q      <= busy_d;
`ifdef FB_SWAP_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAW: begin
        if (done) state_d = ST_WAIT_VSYNC;
        else      state_d = ST_DRAW;
      end
      ST_WAIT_VSYNC: begin
`ifdef FB_SWAP_CLEAR_EN
        if (vsync) state_d = ST_CLEAR;
        else       state_d = ST_WAIT_VSYNC;
`else
        if (vsync) state_d = ST_DRAW;
        else       state_d = ST_WAIT_VSYNC;
`endif
      end
      ST_CLEAR: begin
`ifdef FB_SWAP_CLEAR_EN
        if (clr_last_s) state_d = ST_DRAW;
        else            state_d = ST_CLEAR;
`else
        state_d = ST_DRAW;
`endif
      end
      default: state_d = ST_DRAW;
    endcase
  end

  always_comb begin
    flip_s      = (state_q == ST_WAIT_VSYNC) && vsync;
    front_sel_d = front_sel_q ^ flip_s;
    busy_d      = (state_d != ST_DRAW);
`ifdef FB_SWAP_CLEAR_EN
    swap_d     = (state_q == ST_CLEAR) && clr_last_s;
    clr_we_s   = (state_q == ST_CLEAR) && !clr_last_s;
    clr_addr_s = clr_cnt_q[ADDR_W-1:0];
    if (state_q == ST_CLEAR) clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
    else                     clr_cnt_d = '0;
`else
    swap_d = flip_s;
`endif
  end

  fb_write_stage #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .PIXEL_W  (PIXEL_W),
    .CNT_W    (CNT_W)
`ifdef FB_SWAP_CLEAR_EN
    ,.CLEAR_VAL(CLEAR_VAL)
`endif
  ) u_write (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .draw_en   (state_q == ST_DRAW),
    .back_bank (back_of(front_sel_q)),
    .bb_we     (bb_we),
    .din       (din),
    .waddr     (waddr),
`ifdef FB_SWAP_CLEAR_EN
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
`endif
    .mem_we    (mem_we),
    .mem_bank  (mem_bank),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .drop_cnt  (drop_cnt)
  );

  assign swap      = swap_q;
  assign front_sel = front_sel_q;
  assign busy      = busy_q;

endmodule
